// File: rtl/gg_code_loader.sv
// gg_code_loader: stages cheat entries from the download bus, then wipes and reloads the geniecodes table.
// Optional trailing XOR checksum byte enabled by defining GG_CODE_CHECKSUM_EN.
module gg_code_loader #(
   parameter int MAX_CODES = 9,
   parameter int ENTRY_B   = 5
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ce,
   input  logic        dl_active,
   input  logic        dl_wr,
   input  logic [7:0]  dl_data,
   input  logic        clear,
   output logic [37:0] code,
   output logic        busy,
   output logic [3:0]  num_codes,
   output logic        err
);

`ifdef GG_CODE_CHECKSUM_EN
   localparam int CAP_B = MAX_CODES * ENTRY_B + 1;
`else
   localparam int CAP_B = MAX_CODES * ENTRY_B;
`endif
   localparam int PW = $clog2(CAP_B + 1);
   localparam logic [PW-1:0] PTR_FULL  = PW'(CAP_B);
   localparam logic [3:0]    LAST_SLOT = 4'(MAX_CODES - 1);
   localparam logic [3:0]    NUM_SLOTS = 4'(MAX_CODES);
   localparam logic [2:0]    LAST_SEL  = 3'(ENTRY_B - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WIPE = 2'd1,
      ST_LOAD = 2'd2
   } state_t;

   state_t        r_state;
   logic [3:0]    r_idx;
   logic [3:0]    r_n_pend;
   logic [37:0]   r_code;
   logic          r_busy;
   logic [3:0]    r_num;
   logic          r_err;
   logic          r_dl_d;
   logic [PW-1:0] r_wr_ptr;
   logic [2:0]    r_sel;
   logic [3:0]    r_ent;

   logic          r_en     [MAX_CODES];
   logic          r_cmp_en [MAX_CODES];
   logic [14:0]   r_addr   [MAX_CODES];
   logic [7:0]    r_cmp    [MAX_CODES];
   logic [7:0]    r_rep    [MAX_CODES];

   logic          w_rise;
   logic          w_fall;
   logic [PW-1:0] w_ptr;
   logic [2:0]    w_sel;
   logic [3:0]    w_ent;
   logic          w_full;
   logic          w_accept;
   logic          w_ovf;
   logic [3:0]    w_n;
   logic          w_ck_ok;
   logic          w_commit;
   logic          w_ck_fail;
   logic          w_clear_go;
`ifdef GG_CODE_CHECKSUM_EN
   logic [7:0]    r_xor;
   logic [7:0]    w_xor;
`endif

   assign code      = r_code;
   assign busy      = r_busy;
   assign num_codes = r_num;
   assign err       = r_err;

   // Edge detection, pointer rewind on a new download, and commit sizing
   always_comb begin
      w_rise = dl_active & ~r_dl_d;
      w_fall = ~dl_active & r_dl_d;
      if (w_rise) begin
         w_ptr = '0;
         w_sel = 3'd0;
         w_ent = 4'd0;
      end else begin
         w_ptr = r_wr_ptr;
         w_sel = r_sel;
         w_ent = r_ent;
      end
      w_full   = (w_ptr == PTR_FULL);
      w_accept = dl_active & dl_wr & ~w_full;
      w_ovf    = dl_active & dl_wr & w_full;
`ifdef GG_CODE_CHECKSUM_EN
      w_xor   = w_rise ? 8'h00 : r_xor;
      w_ck_ok = (r_xor == 8'h00);
      // The checksum byte is excluded from the entry count
      if ((r_sel == 3'd0) && (r_ent != 4'd0)) begin
         w_n = r_ent - 4'd1;
      end else begin
         w_n = r_ent;
      end
`else
      w_ck_ok = 1'b1;
      w_n     = r_ent;
`endif
      w_commit   = w_fall & w_ck_ok;
      w_ck_fail  = (r_state == ST_IDLE) & w_fall & ~w_ck_ok;
      w_clear_go = clear & ~dl_active;
   end

   // Download byte counters: total bytes, byte-within-entry and entry index
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dl_d   <= 1'b0;
         r_wr_ptr <= '0;
         r_sel    <= 3'd0;
         r_ent    <= 4'd0;
`ifdef GG_CODE_CHECKSUM_EN
         r_xor    <= 8'h00;
`endif
      end else begin
         r_dl_d <= dl_active;
         if (w_accept) begin
            r_wr_ptr <= w_ptr + PW'(1);
            if (w_sel == LAST_SEL) begin
               r_sel <= 3'd0;
               r_ent <= w_ent + 4'd1;
            end else begin
               r_sel <= w_sel + 3'd1;
               r_ent <= w_ent;
            end
`ifdef GG_CODE_CHECKSUM_EN
            r_xor <= w_xor ^ dl_data;
`endif
         end else begin
            r_wr_ptr <= w_ptr;
            r_sel    <= w_sel;
            r_ent    <= w_ent;
`ifdef GG_CODE_CHECKSUM_EN
            r_xor    <= w_xor;
`endif
         end
      end
   end

   // Staging buffer, decoded per field as bytes arrive; intentionally not reset
   always_ff @(posedge clk) begin
      if (w_accept && (w_ent < NUM_SLOTS)) begin
         case (w_sel)
            3'd0: begin
               r_en[w_ent]     <= dl_data[0];
               r_cmp_en[w_ent] <= dl_data[1];
            end
            3'd1:    r_addr[w_ent][14:8] <= dl_data[6:0];
            3'd2:    r_addr[w_ent][7:0]  <= dl_data;
            3'd3:    r_cmp[w_ent]        <= dl_data;
            3'd4:    r_rep[w_ent]        <= dl_data;
            default: ;
         endcase
      end
   end

   // Wipe/load sequencer with registered code, busy and status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= 4'd0;
         r_n_pend <= 4'd0;
         r_code   <= 38'd0;
         r_busy   <= 1'b0;
         r_num    <= 4'd0;
         r_err    <= 1'b0;
      end else begin
         if (w_rise) begin
            r_err <= 1'b0;
         end else if (w_ovf || w_ck_fail) begin
            r_err <= 1'b1;
         end else begin
            r_err <= r_err;
         end
         case (r_state)
            ST_IDLE: begin
               r_code <= 38'd0;
               r_idx  <= 4'd0;
               if (w_commit) begin
                  r_state  <= ST_WIPE;
                  r_n_pend <= w_n;
                  r_busy   <= 1'b1;
               end else if (w_clear_go) begin
                  r_state  <= ST_WIPE;
                  r_n_pend <= 4'd0;
                  r_busy   <= 1'b1;
               end else begin
                  r_busy <= 1'b0;
               end
            end
            ST_WIPE: begin
               if (w_rise) begin
                  r_state <= ST_IDLE;
                  r_code  <= 38'd0;
                  r_busy  <= 1'b0;
                  r_idx   <= 4'd0;
               end else if (ce) begin
                  r_code <= {1'b1, r_idx, 33'd0};
                  if (r_idx == LAST_SLOT) begin
                     r_idx <= 4'd0;
                     if (r_n_pend == 4'd0) begin
                        r_state <= ST_IDLE;
                        r_num   <= 4'd0;
                     end else begin
                        r_state <= ST_LOAD;
                     end
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end else begin
                  r_code <= 38'd0;
               end
            end
            ST_LOAD: begin
               if (w_rise) begin
                  r_state <= ST_IDLE;
                  r_code  <= 38'd0;
                  r_busy  <= 1'b0;
                  r_idx   <= 4'd0;
               end else if (ce) begin
                  r_code <= {1'b1, r_idx, r_en[r_idx], r_cmp_en[r_idx],
                             r_addr[r_idx], r_cmp[r_idx], r_rep[r_idx]};
                  if (r_idx == (r_n_pend - 4'd1)) begin
                     r_state <= ST_IDLE;
                     r_idx   <= 4'd0;
                     r_num   <= r_n_pend;
                  end else begin
                     r_idx <= r_idx + 4'd1;
                  end
               end else begin
                  r_code <= 38'd0;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_code  <= 38'd0;
               r_busy  <= 1'b0;
               r_idx   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gg_code_loader.sv
// Scoreboard bench for gg_code_loader: expected strobes are queued at commit and
// popped by a monitor on the falling clock edge.
`timescale 1ns/1ps
module tb_gg_code_loader;
   localparam int MAXC = 9;
   localparam int EB   = 5;
`ifdef GG_CODE_CHECKSUM_EN
   localparam bit CK   = 1'b1;
   localparam int CAPB = MAXC * EB + 1;
`else
   localparam bit CK   = 1'b0;
   localparam int CAPB = MAXC * EB;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce = 1'b0;
   logic        dl_active = 1'b0;
   logic        dl_wr = 1'b0;
   logic [7:0]  dl_data = 8'h00;
   logic        clear = 1'b0;
   logic [37:0] code;
   logic        busy;
   logic [3:0]  num_codes;
   logic        err;

   gg_code_loader #(.MAX_CODES(MAXC), .ENTRY_B(EB)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ce        (ce),
      .dl_active (dl_active),
      .dl_wr     (dl_wr),
      .dl_data   (dl_data),
      .clear     (clear),
      .code      (code),
      .busy      (busy),
      .num_codes (num_codes),
      .err       (err)
   );

   always #5 clk = ~clk;

   int          n_vec = 0;
   int          n_err = 0;
   logic [37:0] exp_q[$];
   logic [7:0]  tx_q[$];
   logic [3:0]  exp_num = 4'd0;
   logic [3:0]  pend_num = 4'd0;
   bit          pend_valid = 1'b0;
   logic        exp_err = 1'b0;
   logic        ce_at_edge = 1'b0;
   bit          mon_en = 1'b0;
   logic [37:0] mon_e;
   int          ckm = CK ? 1 : 0;

   always @(posedge clk) ce_at_edge <= ce;

   // Strobes must be preceded by ce and match the scoreboard head in order
   always @(negedge clk) begin
      if (mon_en) begin
         if (code[37]) begin
            n_vec++;
            if (ce_at_edge !== 1'b1) begin
               n_err++;
               $display("FAIL strobe_without_ce: code=%h ce=%b, required ce=1", code, ce_at_edge);
            end
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_strobe: code=%h, required no strobe", code);
            end else begin
               mon_e = exp_q.pop_front();
               if (code !== mon_e) begin
                  n_err++;
                  $display("FAIL strobe_data: got %h, expected %h", code, mon_e);
               end
            end
         end else if (code !== 38'd0) begin
            n_err++;
            $display("FAIL idle_code: got %h, expected 0", code);
         end
      end
   end

   function automatic logic [37:0] load_word(input int j);
      logic [7:0] f, a1, a0, c, r;
      f  = tx_q[j*EB];
      a1 = tx_q[j*EB+1];
      a0 = tx_q[j*EB+2];
      c  = tx_q[j*EB+3];
      r  = tx_q[j*EB+4];
      return {1'b1, 4'(j), f[0], f[1], a1[6:0], a0, c, r};
   endfunction

   task automatic push_wipes();
      for (int i = 0; i < MAXC; i++) exp_q.push_back({1'b1, 4'(i), 33'd0});
   endtask

   // ck_mode: 0 no checksum byte, 1 correct checksum, 2 corrupted checksum
   task automatic dl_send(input int ck_mode, input bit hold_clear);
      logic [7:0] x;
      int acc, n;
      bit ok;
      if (ck_mode != 0) begin
         x = 8'h00;
         foreach (tx_q[i]) x = x ^ tx_q[i];
         tx_q.push_back((ck_mode == 1) ? x : (x ^ 8'h5A));
      end
      @(negedge clk); dl_active = 1'b1; exp_err = 1'b0; clear = hold_clear;
      foreach (tx_q[i]) begin
         @(negedge clk); dl_wr = 1'b1; dl_data = tx_q[i];
      end
      @(negedge clk); dl_wr = 1'b0;
      @(negedge clk); dl_active = 1'b0;
      acc = (tx_q.size() > CAPB) ? CAPB : tx_q.size();
      if (tx_q.size() > CAPB) exp_err = 1'b1;
      x = 8'h00;
      for (int i = 0; i < acc; i++) x = x ^ tx_q[i];
      ok = !CK || (x == 8'h00);
      n = CK ? ((acc > 0) ? (acc - 1) / EB : 0) : acc / EB;
      if (n > MAXC) n = MAXC;
      if (ok) begin
         push_wipes();
         for (int j = 0; j < n; j++) exp_q.push_back(load_word(j));
         pend_num   = 4'(n);
         pend_valid = 1'b1;
      end else begin
         exp_err    = 1'b1;
         pend_valid = 1'b0;
      end
   endtask

   task automatic wait_done(input string tag);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && k < 400) begin
         @(negedge clk);
         k++;
      end
      n_vec++;
      if (k >= 400) begin
         n_err++;
         $display("FAIL %s_timeout: %0d strobes outstanding busy=%b, required 0 and 0", tag, exp_q.size(), busy);
      end
      if (pend_valid) begin
         exp_num    = pend_num;
         pend_valid = 1'b0;
      end
      n_vec++;
      if (num_codes !== exp_num) begin
         n_err++;
         $display("FAIL %s_num_codes: got %0d, expected %0d", tag, num_codes, exp_num);
      end
      n_vec++;
      if (err !== exp_err) begin
         n_err++;
         $display("FAIL %s_err: got %b, expected %b", tag, err, exp_err);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; ce = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++; if (code !== 38'd0) begin n_err++; $display("FAIL reset_code: got %h, expected 0", code); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, expected 0", busy); end
      n_vec++; if (num_codes !== 4'd0) begin n_err++; $display("FAIL reset_num: got %0d, expected 0", num_codes); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b, expected 0", err); end
      reset_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
   endtask

   task automatic test_basic();
      logic [7:0] b [10] = '{8'h01, 8'h92, 8'h34, 8'h56, 8'h78, 8'h03, 8'h0A, 8'hBC, 8'h11, 8'h22};
      tx_q.delete();
      foreach (b[i]) tx_q.push_back(b[i]);
      dl_send(ckm, 1'b0);
      @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL basic_busy_rise: got %b, expected 1", busy); end
      n_vec++; if (code !== 38'd0) begin n_err++; $display("FAIL basic_trigger_code: got %h, expected 0", code); end
      wait_done("basic");
   endtask

   task automatic test_partial();
      tx_q.delete();
      for (int i = 0; i < 12; i++) tx_q.push_back(8'(8'h21 + i * 13));
      dl_send(ckm, 1'b0);
      wait_done("partial");
   endtask

   task automatic test_overflow();
      tx_q.delete();
      for (int i = 0; i < 50; i++) tx_q.push_back(8'(i * 7 + 3));
      dl_send(ckm, 1'b0);
      wait_done("overflow");
   endtask

   task automatic test_abort();
      logic [7:0] b [10] = '{8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h03, 8'h45, 8'h67, 8'h89, 8'hAB};
      tx_q.delete();
      foreach (b[i]) tx_q.push_back(b[i]);
      dl_send(ckm, 1'b0);
      repeat (11) @(negedge clk);
      dl_active = 1'b1;
      @(negedge clk);
      n_vec++; if (code !== 38'd0) begin n_err++; $display("FAIL abort_code: got %h, expected 0", code); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b, expected 0", busy); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL abort_err: got %b, expected 0", err); end
      n_vec++; if (exp_q.size() != 1) begin n_err++; $display("FAIL abort_strobes_left: got %0d, expected 1", exp_q.size()); end
      n_vec++; if (num_codes !== exp_num) begin n_err++; $display("FAIL abort_num: got %0d, expected %0d", num_codes, exp_num); end
      exp_q.delete();
      pend_valid = 1'b0;
      repeat (5) @(negedge clk);
      tx_q.delete();
      for (int i = 0; i < 5; i++) tx_q.push_back(8'(8'hC1 + i));
      dl_send(ckm, 1'b0);
      wait_done("abort_reload");
   endtask

   task automatic test_clear_gap();
      @(negedge clk); clear = 1'b1;
      push_wipes(); pend_num = 4'd0; pend_valid = 1'b1;
      @(negedge clk); clear = 1'b0;
      @(negedge clk);
      @(negedge clk);
      ce = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_vec++; if (code !== 38'd0) begin n_err++; $display("FAIL gap_code: got %h, expected 0", code); end
         n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL gap_busy: got %b, expected 1", busy); end
      end
      ce = 1'b1;
      wait_done("clear");
   endtask

   task automatic test_clear_collide();
      tx_q.delete();
      for (int i = 0; i < 5; i++) tx_q.push_back(8'(8'h3B + i * 17));
      dl_send(ckm, 1'b1);
      @(negedge clk); clear = 1'b0;
      @(negedge clk);
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      wait_done("collide");
   endtask

`ifdef GG_CODE_CHECKSUM_EN
   task automatic test_checksum_bad();
      tx_q.delete();
      for (int i = 0; i < 10; i++) tx_q.push_back(8'(8'h5C + i * 3));
      dl_send(2, 1'b0);
      repeat (30) @(negedge clk);
      wait_done("checksum_bad");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_partial();
      test_overflow();
      test_abort();
      test_clear_gap();
      test_clear_collide();
`ifdef GG_CODE_CHECKSUM_EN
      test_checksum_bad();
`endif
      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
